pattern_expander: RTL and testbench
===================================

# pattern_expander

Parametrised, streaming successor to the fixed 4-to-8-bit generic expander. Accepts IN_W-bit words with a per-word mode over a valid/ready input and converts each into a 2*IN_W-bit pattern. Results are buffered in a DEPTH-entry output FIFO and presented on a valid/ready output with a saturating transfer counter. It sits between a stimulus source and any downstream consumer that may apply backpressure.

## Interface
- IN_W, 4, input word width (≥1)
- DEPTH, 2, output FIFO entries (power of 2, ≥2)
- CNT_W, 8, width of transfer counter
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-low
- in_valid  in  1  input word present
- in_ready  out  1  block can accept a word this cycle
- in_data  in  IN_W  input word
- in_mode  in  2  expansion mode, sampled with in_data
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  2*IN_W  expanded pattern
- xfer_cnt  out  CNT_W  completed output transfers, saturating

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Expansion is combinational on in_data/in_mode at acceptance, then written into the FIFO tail. The mode travels with its word.
- Mode 0, DUP: each bit doubled, so bit i maps to out bits 2i+1:2i = {b_i,b_i}. 0101 → 00110011.
- Mode 1, MANCH: bit i maps to {b_i,~b_i}. 0101 → 01100110.
- Mode 2, REP: {in,in}. 0101 → 01010101.
- Mode 3, REPN: {~in,~in}. 0101 → 10101010.
- FIFO: occupancy count 0..DEPTH, with wrapping read and write pointers of log2(DEPTH) bits.
- in_ready = (count < DEPTH). It is a function of registered count only, with no combinational path from out_ready.
- out_valid = (count != 0). out_data = mem[rd_ptr].
- Simultaneous push and pop: count unchanged, both pointers advance.
- When full, in_ready=0 even if out_ready=1 in the same cycle. No push-through.
- xfer_cnt increments on each output transfer and holds at 2^CNT_W−1.
- Reset values, applied at a rising edge with reset=0:
  - count=0, pointers=0, xfer_cnt=0
  - out_valid=0, in_ready=1
  - out_data is don't-care. The bench must not check it while out_valid=0.
- Reset mid-operation flushes all buffered words. Transfers presented in the reset cycle are dropped.

## Timing
- Latency: a word accepted at edge N is visible on out_valid/out_data after edge N, i.e. one cycle.
- Throughput: one word per cycle while out_ready is held high. No bubbles when count is 1 and push and pop coincide.
- in_ready deasserts the cycle after the push that makes count=DEPTH. It reasserts the cycle after the first pop from full.
- out_data and out_valid must stay stable while out_valid=1 and out_ready=0.
- Wrap-around: pointers wrap modulo DEPTH. Order is preserved across wrap.

## Structure
- Package pattern_expander_pkg:
  - 2-bit mode constants MODE_DUP=0, MODE_MANCH=1, MODE_REP=2, MODE_REPN=3.
  - Function expand(data, mode) parametrised via IN_W.
- Sub-module sync_fifo (WIDTH, DEPTH) holds memory, pointers, count, and the full/empty flags.
- Top level contains the expand logic, the handshake glue and xfer_cnt.

## Test plan
- Reset then mode 3: after 50 ns of reset=0, send 0101 with out_ready=1 → next cycle out_valid=1, out_data=10101010, xfer_cnt=1.
- Mode sweep: in_data=0101 in modes 0, 1, 2, 3 back-to-back with out_ready=1 → outputs 00110011, 01100110, 01010101, 10101010 in order on consecutive cycles.
- Backpressure: out_ready=0, push 3 words with DEPTH=2.
  - in_ready drops after the 2nd push and the 3rd word is not accepted.
  - Head is stable.
  - Raise out_ready → two words drain in order, and in_ready returns one cycle after the first pop.
- Wrap and simultaneous push/pop: stream 10 words, 0000..1001, in mode 2 with out_ready toggling 1,0.
  - All 10 emerge in order with correct {in,in}.
  - Count never exceeds DEPTH.
- Saturation: CNT_W=3, 10 transfers → xfer_cnt reads 7 and holds.
- Mid-operation reset: fill the FIFO, then pulse reset=0 for one cycle → next cycle out_valid=0, in_ready=1, xfer_cnt=0. The subsequent word emerges alone. IN_W=8 regression: 0xA5 in mode 0 → 0xCC33.

Source files
------------

// File: rtl/pattern_expander_pkg.sv
// pattern_expander_pkg: shared definitions for the pattern expander slice.
//   - mode_e     : 2-bit expansion mode travelling with each input word
//   - EXP_MAX_W  : widest input word the expand() helper supports
//   - expand()   : maps an input word to its 2x-wide pattern
// Callers zero-extend their word to EXP_MAX_W bits and pass the real width.
// They then keep the low 2*in_w bits of the result.
package pattern_expander_pkg;

    typedef enum logic [1:0] {
        MODE_DUP   = 2'd0,  // bit i -> {b_i, b_i}
        MODE_MANCH = 2'd1,  // bit i -> {b_i, ~b_i}
        MODE_REP   = 2'd2,  // {in, in}
        MODE_REPN  = 2'd3   // {~in, ~in}
    } mode_e;

    localparam int EXP_MAX_W = 32;
    localparam int EXP_OUT_W = 2 * EXP_MAX_W;

    // Bits above 2*in_w in the result are meaningless and must be dropped by the caller.
    function automatic logic [EXP_OUT_W-1:0] expand(
        input logic [EXP_MAX_W-1:0] data,
        input logic [1:0]           mode,
        input int                   in_w
    );
        logic [EXP_OUT_W-1:0] dext;
        logic [EXP_OUT_W-1:0] one;
        logic [EXP_OUT_W-1:0] b;
        logic [EXP_OUT_W-1:0] res;
        dext = {{EXP_MAX_W{1'b0}}, data};
        one  = {{(EXP_OUT_W-1){1'b0}}, 1'b1};
        res  = {EXP_OUT_W{1'b0}};
        case (mode_e'(mode))
            MODE_DUP: begin
                for (int i = 0; i < EXP_MAX_W; i++) begin
                    b   = (dext >> i) & one;
                    res = res | (b << (2 * i + 1)) | (b << (2 * i));
                end
            end
            MODE_MANCH: begin
                for (int i = 0; i < EXP_MAX_W; i++) begin
                    b   = (dext >> i) & one;
                    res = res | (b << (2 * i + 1)) | ((b ^ one) << (2 * i));
                end
            end
            MODE_REP: begin
                res = dext | (dext << in_w);
            end
            MODE_REPN: begin
                // Inversion spills ones above 2*in_w; those bits are discarded by the caller.
                res = ~(dext | (dext << in_w));
            end
            default: begin
                res = {EXP_OUT_W{1'b0}};
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pattern_expander_if.sv
// pattern_expander_if: input/output handshake bundle of the pattern expander.
//   in_valid/in_ready/in_data/in_mode : word stream into the block
//   out_valid/out_ready/out_data      : expanded pattern stream out of the block
//   xfer_cnt                          : saturating count of completed output transfers
// modport slave is the block side; modport master is the source/consumer side.
interface pattern_expander_if #(
    parameter int IN_W  = 4,
    parameter int CNT_W = 8
);
    import pattern_expander_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_W-1:0]      in_data;
    logic [1:0]           in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*IN_W-1:0]    out_data;
    logic [CNT_W-1:0]     xfer_cnt;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, xfer_cnt
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, xfer_cnt
    );

endinterface

// File: rtl/pattern_expander_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrapping pointers and an occupancy count.
//   clk, reset (synchronous, active-low)
//   push/wr_data : write at tail (ignored when full)
//   pop/rd_data  : advance head (ignored when empty); rd_data = mem[rd_ptr]
//   full/empty   : decoded from the registered count only
module sync_fifo
    import pattern_expander_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]  CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Flags come from the registered count so no input reaches them combinationally.
    always_comb begin
        full      = (count_r == CNT_FULL);
        empty     = (count_r == {(AW + 1){1'b0}});
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        rd_data   = mem_r[rd_ptr_r];
    end

    // Occupancy update; a coinciding push and pop leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers and count; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Storage array; contents are don't-care after reset since the pointers restart.
    always_ff @(posedge clk) begin
        if (push_ok_s && reset) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/pattern_expander.sv
// pattern_expander: streams IN_W-bit words (with a per-word mode) into 2*IN_W-bit
// patterns, buffered in a DEPTH-entry FIFO.
//   clk   : clock, rising edge
//   reset : synchronous, active-low; flushes the FIFO and clears xfer_cnt
//   bus   : pattern_expander_if.slave
//           in_valid/in_ready/in_data/in_mode, out_valid/out_ready/out_data, xfer_cnt
// in_ready depends only on the registered occupancy, so a full FIFO never
// accepts a word even when the consumer drains in the same cycle.
module pattern_expander
    import pattern_expander_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pattern_expander_if.slave    bus
);

    localparam int               OUT_W   = 2 * IN_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [EXP_MAX_W-1:0] data_ext_s;
    logic [EXP_OUT_W-1:0] exp_full_s;
    logic [OUT_W-1:0]     exp_s;
    logic [OUT_W-1:0]     head_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic [CNT_W-1:0]     xfer_cnt_r;

    // Expansion of the word currently offered; only its low OUT_W bits are meaningful.
    always_comb begin
        data_ext_s = EXP_MAX_W'(bus.in_data);
        exp_full_s = expand(data_ext_s, bus.in_mode, IN_W);
        exp_s      = exp_full_s[OUT_W-1:0];
    end

    // Discarded upper bits of the wide helper result.
    if (OUT_W < EXP_OUT_W) begin : g_exp_upper
        logic exp_upper_unused_s;
        assign exp_upper_unused_s = ^exp_full_s[EXP_OUT_W-1:OUT_W];
    end

    // Handshake glue between the streams and the FIFO.
    always_comb begin
        push_s        = bus.in_valid && !full_s;
        pop_s         = bus.out_ready && !empty_s;
        bus.in_ready  = !full_s;
        bus.out_valid = !empty_s;
        bus.out_data  = head_s;
        bus.xfer_cnt  = xfer_cnt_r;
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (exp_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Output transfer counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            xfer_cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s && (xfer_cnt_r != CNT_MAX)) begin
            xfer_cnt_r <= xfer_cnt_r + CNT_ONE;
        end else begin
            xfer_cnt_r <= xfer_cnt_r;
        end
    end

endmodule

// File: tb/tb_pattern_expander.sv
// tb_pattern_expander: directed + random checks of two pattern_expander instances
// (IN_W=4/DEPTH=2/CNT_W=3 and IN_W=8/DEPTH=4/CNT_W=8) against a queue-based model.
module tb_pattern_expander;

    localparam int A_W = 4;
    localparam int A_D = 2;
    localparam int A_C = 3;
    localparam int B_W = 8;
    localparam int B_D = 4;
    localparam int B_C = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    pattern_expander_if #(.IN_W(A_W), .CNT_W(A_C)) bus_a ();
    pattern_expander_if #(.IN_W(B_W), .CNT_W(B_C)) bus_b ();

    pattern_expander #(.IN_W(A_W), .DEPTH(A_D), .CNT_W(A_C)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pattern_expander #(.IN_W(B_W), .DEPTH(B_D), .CNT_W(B_C)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    int          xfer_a   = 0;
    int          xfer_b   = 0;

    // Expected pattern from the mode rules, computed with plain arithmetic.
    function automatic longint unsigned model_expand(int w, longint unsigned d, int mode);
        longint unsigned mask;
        longint unsigned r;
        mask = (64'd1 << w) - 64'd1;
        d    = d & mask;
        r    = 64'd0;
        case (mode)
            0: for (int i = 0; i < w; i++) r += ((d >> i) & 64'd1) * 64'd3 * (64'd1 << (2 * i));
            1: for (int i = 0; i < w; i++) r += (((d >> i) & 64'd1) != 0 ? 64'd2 : 64'd1) * (64'd1 << (2 * i));
            2: r = d * ((64'd1 << w) + 64'd1);
            default: r = (mask ^ d) * ((64'd1 << w) + 64'd1);
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        check("a_in_ready", 64'(bus_a.in_ready), 64'(q_a.size() < A_D));
        check("a_out_valid", 64'(bus_a.out_valid), 64'(q_a.size() != 0));
        if (q_a.size() != 0) check("a_out_data", 64'(bus_a.out_data), q_a[0]);
        check("a_xfer_cnt", 64'(bus_a.xfer_cnt), 64'(xfer_a));
        check("b_in_ready", 64'(bus_b.in_ready), 64'(q_b.size() < B_D));
        check("b_out_valid", 64'(bus_b.out_valid), 64'(q_b.size() != 0));
        if (q_b.size() != 0) check("b_out_data", 64'(bus_b.out_data), q_b[0]);
        check("b_xfer_cnt", 64'(bus_b.xfer_cnt), 64'(xfer_b));
    endtask

    // One clock: predict handshakes from the model, take the edge, update, then check.
    task automatic cycle();
        bit acc_a;
        bit pop_a;
        bit acc_b;
        bit pop_b;
        logic [63:0] w_a;
        logic [63:0] w_b;
        acc_a = bus_a.in_valid && (q_a.size() < A_D);
        pop_a = bus_a.out_ready && (q_a.size() != 0);
        acc_b = bus_b.in_valid && (q_b.size() < B_D);
        pop_b = bus_b.out_ready && (q_b.size() != 0);
        w_a   = model_expand(A_W, 64'(bus_a.in_data), int'(bus_a.in_mode));
        w_b   = model_expand(B_W, 64'(bus_b.in_data), int'(bus_b.in_mode));
        @(posedge clk);
        if (!reset) begin
            q_a.delete();
            q_b.delete();
            xfer_a = 0;
            xfer_b = 0;
        end else begin
            if (pop_a) begin
                void'(q_a.pop_front());
                if (xfer_a < (1 << A_C) - 1) xfer_a++;
            end
            if (acc_a) q_a.push_back(w_a);
            if (pop_b) begin
                void'(q_b.pop_front());
                if (xfer_b < (1 << B_C) - 1) xfer_b++;
            end
            if (acc_b) q_b.push_back(w_b);
        end
        #1;
        check_state();
    endtask

    initial begin
        logic [7:0]  sweep_exp [4];
        logic [63:0] head;
        int          idx;
        bit          acc;

        sweep_exp = '{8'h33, 8'h66, 8'h55, 8'hAA};
        bus_a.in_valid = 1'b0; bus_a.in_data = 4'h0; bus_a.in_mode = 2'd0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00; bus_b.in_mode = 2'd0; bus_b.out_ready = 1'b0;

        // Reset held low for 50 ns.
        reset = 1'b0;
        repeat (5) cycle();
        check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
        reset = 1'b1;

        // Mode 3 after reset.
        bus_a.in_valid = 1'b1; bus_a.in_data = 4'b0101; bus_a.in_mode = 2'd3; bus_a.out_ready = 1'b1;
        cycle();
        check("m3_out_valid", 64'(bus_a.out_valid), 64'd1);
        check("m3_out_data", 64'(bus_a.out_data), 64'hAA);
        bus_a.in_valid = 1'b0;
        cycle();
        check("m3_xfer_cnt", 64'(bus_a.xfer_cnt), 64'd1);

        // Mode sweep back-to-back.
        bus_a.in_valid = 1'b1; bus_a.in_data = 4'b0101;
        for (int m = 0; m < 4; m++) begin
            bus_a.in_mode = 2'(m);
            cycle();
            check("sweep_data", 64'(bus_a.out_data), 64'(sweep_exp[m]));
        end
        bus_a.in_valid = 1'b0;
        cycle();

        // Backpressure: three pushes into a two-entry FIFO.
        bus_a.out_ready = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_mode = 2'd2;
        bus_a.in_data = 4'h1; cycle();
        head = 64'(bus_a.out_data);
        bus_a.in_data = 4'h2; cycle();
        check("bp_in_ready_low", 64'(bus_a.in_ready), 64'd0);
        bus_a.in_data = 4'h3; cycle();
        check("bp_head_stable", 64'(bus_a.out_data), head);
        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
        cycle();
        check("bp_in_ready_back", 64'(bus_a.in_ready), 64'd1);
        check("bp_second_word", 64'(bus_a.out_data), 64'h22);
        cycle();
        check("bp_drained", 64'(bus_a.out_valid), 64'd0);

        // Wrap-around with simultaneous push/pop, out_ready toggling 1,0.
        idx = 0;
        bus_a.in_mode = 2'd2;
        for (int c = 0; c < 60; c++) begin
            if (idx >= 10 && q_a.size() == 0) break;
            bus_a.in_valid  = (idx < 10);
            bus_a.in_data   = 4'(idx);
            bus_a.out_ready = (c % 2 == 0);
            acc = bus_a.in_valid && (q_a.size() < A_D);
            cycle();
            if (acc) idx++;
        end
        check("wrap_all_sent", 64'(idx), 64'd10);
        check("wrap_all_drained", 64'(bus_a.out_valid), 64'd0);
        bus_a.in_valid = 1'b0;

        // Saturation of the 3-bit counter.
        reset = 1'b0; cycle(); reset = 1'b1;
        bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            bus_a.in_data = 4'($urandom_range(15, 0));
            bus_a.in_mode = 2'($urandom_range(3, 0));
            cycle();
        end
        bus_a.in_valid = 1'b0;
        cycle();
        check("sat_xfer_cnt", 64'(bus_a.xfer_cnt), 64'd7);
        cycle();
        check("sat_hold", 64'(bus_a.xfer_cnt), 64'd7);

        // Mid-operation reset flushes buffered words.
        bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b0; bus_a.in_mode = 2'd0;
        repeat (3) cycle();
        reset = 1'b0; bus_a.out_ready = 1'b1;
        cycle();
        check("mrst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("mrst_in_ready", 64'(bus_a.in_ready), 64'd1);
        check("mrst_xfer_cnt", 64'(bus_a.xfer_cnt), 64'd0);
        reset = 1'b1;
        bus_a.in_valid = 1'b1; bus_a.in_data = 4'h9; bus_a.in_mode = 2'd1; bus_a.out_ready = 1'b0;
        cycle();
        bus_a.in_valid = 1'b0;
        cycle();
        check("mrst_word_data", 64'(bus_a.out_data), 64'h96);
        bus_a.out_ready = 1'b1;
        cycle();
        check("mrst_word_alone", 64'(bus_a.out_valid), 64'd0);

        // IN_W=8 regression.
        bus_b.in_valid = 1'b1; bus_b.in_data = 8'hA5; bus_b.in_mode = 2'd0; bus_b.out_ready = 1'b0;
        cycle();
        check("w8_dup_a5", 64'(bus_b.out_data), 64'hCC33);
        bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
        cycle();

        // Random traffic on both instances.
        for (int k = 0; k < 300; k++) begin
            bus_a.in_valid  = 1'($urandom_range(1, 0));
            bus_a.in_data   = 4'($urandom_range(15, 0));
            bus_a.in_mode   = 2'($urandom_range(3, 0));
            bus_a.out_ready = 1'($urandom_range(1, 0));
            bus_b.in_valid  = 1'($urandom_range(1, 0));
            bus_b.in_data   = 8'($urandom_range(255, 0));
            bus_b.in_mode   = 2'($urandom_range(3, 0));
            bus_b.out_ready = ($urandom_range(3, 0) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
